// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM. Each access takes one
// IDLE decision cycle and one ACCESS cycle. Round-robin or fixed priority.
module ram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    input  logic [DATA_W-1:0] ram_data_out
);
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state;
    logic       sel;
    logic       rr_last;
    logic [7:0] wait_cnt;
    logic       win;
    logic       win_we;

    always_comb begin
        // NOTE: every output of this block is assigned first, so no path can infer a latch.
        win = m1_req;
        if (m0_req && m1_req)
            win = (FIXED_PRIO != 0) ? (wait_cnt != WAIT_MAX) : !rr_last;
        win_we = win ? m1_we : m0_we;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            sel              <= 1'b0;
            rr_last          <= 1'b1;
            wait_cnt         <= '0;
            m0_gnt           <= 1'b0;
            m1_gnt           <= 1'b0;
            m0_rvalid        <= 1'b0;
            m1_rvalid        <= 1'b0;
            m0_rdata         <= '0;
            m1_rdata         <= '0;
            ram_address      <= '0;
            ram_data_in      <= '0;
            ram_write_enable <= 1'b0;
            ram_read_enable  <= 1'b0;
        end else begin
            m0_gnt           <= 1'b0;
            m1_gnt           <= 1'b0;
            m0_rvalid        <= 1'b0;
            m1_rvalid        <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_read_enable  <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        sel              <= win;
                        ram_address      <= win ? m1_addr : m0_addr;
                        ram_data_in      <= win ? m1_wdata : m0_wdata;
                        ram_write_enable <= win_we;
                        ram_read_enable  <= !win_we;
                        m0_gnt           <= !win;
                        m1_gnt           <= win;
                        state            <= ACCESS;
                        // Starvation guard: count refusals of a waiting port 0.
                        if (FIXED_PRIO != 0 && m0_req) begin
                            if (!win)
                                wait_cnt <= '0;
                            else if (wait_cnt != WAIT_MAX)
                                wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
                ACCESS: begin
                    rr_last <= sel;
                    if (ram_read_enable) begin
                        if (sel) begin
                            m1_rdata  <= ram_data_out;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= ram_data_out;
                            m0_rvalid <= 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: a round-robin instance on a RAM model and a fixed-priority
// instance (MAX_WAIT = 3) checked for its grant pattern.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [11:0] m0_addr = 0, m1_addr = 0;
    logic [31:0] m0_wdata = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [11:0] ram_address;
    logic [31:0] ram_data_in, ram_data_out;
    logic        ram_write_enable, ram_read_enable;

    logic        f_m0_req = 0, f_m1_req = 0;
    logic        f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid;
    logic [31:0] f_m0_rdata, f_m1_rdata;
    logic [11:0] f_ram_address;
    logic [31:0] f_ram_data_in;
    logic        f_ram_we, f_ram_re;

    logic [31:0] mem [0:4095];
    logic        bd_we = 0;
    logic [11:0] bd_addr = 0;
    logic [31:0] bd_data = 0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_write_enable) mem[ram_address] <= ram_data_in;
    end
    assign ram_data_out = mem[ram_address];

    ram_arbiter #(.ADDR_W(12), .DATA_W(32), .FIXED_PRIO(0), .MAX_WAIT(8)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
        .ram_data_out(ram_data_out)
    );

    ram_arbiter #(.ADDR_W(12), .DATA_W(32), .FIXED_PRIO(1), .MAX_WAIT(3)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .m0_req(f_m0_req), .m0_we(1'b0), .m0_addr(12'h100), .m0_wdata(32'h0),
        .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
        .m1_req(f_m1_req), .m1_we(1'b0), .m1_addr(12'h200), .m1_wdata(32'h0),
        .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
        .ram_address(f_ram_address), .ram_data_in(f_ram_data_in),
        .ram_write_enable(f_ram_we), .ram_read_enable(f_ram_re),
        .ram_data_out({20'h0, f_ram_address})
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_enable, ram_read_enable} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl_during: got %b want 000000",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_enable, ram_read_enable});
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_enable, ram_read_enable,
                 f_m0_gnt, f_m1_gnt} !== 8'b0) begin
                n_err++;
                $display("FAIL reset_idle_ctrl cycle %0d: got %b want 00000000", k,
                         {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_enable, ram_read_enable,
                          f_m0_gnt, f_m1_gnt});
            end
        end
        n_cmp++;
        if ({ram_address, ram_data_in, m0_rdata, m1_rdata} !== 108'b0) begin
            n_err++;
            $display("FAIL reset_data: addr=%h din=%h r0=%h r1=%h want all 0",
                     ram_address, ram_data_in, m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_write_read();
        m0_req = 1; m0_we = 1; m0_addr = 12'h005; m0_wdata = 32'hDEADBEEF;
        n_cmp++;
        if (m0_gnt !== 1'b0 || ram_write_enable !== 1'b0) begin
            n_err++;
            $display("FAIL wr_t0: gnt=%b we=%b want 0 0", m0_gnt, ram_write_enable);
        end
        tick();
        n_cmp++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || ram_write_enable !== 1'b1 ||
            ram_read_enable !== 1'b0 || ram_address !== 12'h005 || ram_data_in !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wr_t1: gnt0=%b gnt1=%b we=%b re=%b addr=%h din=%h want 1 0 1 0 005 deadbeef",
                     m0_gnt, m1_gnt, ram_write_enable, ram_read_enable, ram_address, ram_data_in);
        end
        m0_req = 0;
        tick();
        n_cmp++;
        if (m0_gnt !== 1'b0 || ram_write_enable !== 1'b0 || m0_rvalid !== 1'b0 || mem[12'h005] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wr_t2: gnt=%b we=%b rvalid=%b mem=%h want 0 0 0 deadbeef",
                     m0_gnt, ram_write_enable, m0_rvalid, mem[12'h005]);
        end
        m0_req = 1; m0_we = 0; m0_addr = 12'h005;
        tick();
        n_cmp++;
        if (m0_gnt !== 1'b1 || ram_read_enable !== 1'b1 || ram_write_enable !== 1'b0 || m0_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_t1: gnt=%b re=%b we=%b rvalid=%b want 1 1 0 0",
                     m0_gnt, ram_read_enable, ram_write_enable, m0_rvalid);
        end
        m0_req = 0;
        tick();
        n_cmp++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0 || ram_read_enable !== 1'b0) begin
            n_err++;
            $display("FAIL rd_t2: rvalid0=%b rdata=%h rvalid1=%b re=%b want 1 deadbeef 0 0",
                     m0_rvalid, m0_rdata, m1_rvalid, ram_read_enable);
        end
        tick();
        n_cmp++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rd_hold: rvalid=%b rdata=%h want 0 deadbeef", m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_round_robin();
        preload(12'h020, 32'hA1A1A1A1);
        preload(12'h021, 32'hB2B2B2B2);
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 12'h020;
        m1_req = 1; m1_we = 0; m1_addr = 12'h021;
        for (int k = 1; k <= 8; k++) begin
            logic e_g0, e_g1, e_v0, e_v1;
            tick();
            e_g0 = (k % 4 == 1);
            e_g1 = (k % 4 == 3);
            e_v0 = (k % 4 == 2);
            e_v1 = (k % 4 == 0);
            n_cmp++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== {e_g0, e_g1, e_v0, e_v1}) begin
                n_err++;
                $display("FAIL rr_cycle %0d: gnt0 gnt1 rv0 rv1 = %b want %b", k,
                         {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, {e_g0, e_g1, e_v0, e_v1});
            end
            if (e_v0 || e_v1) begin
                n_cmp++;
                if ((e_v0 && m0_rdata !== 32'hA1A1A1A1) || (e_v1 && m1_rdata !== 32'hB2B2B2B2)) begin
                    n_err++;
                    $display("FAIL rr_rdata %0d: r0=%h r1=%h want a1a1a1a1 / b2b2b2b2", k, m0_rdata, m1_rdata);
                end
            end
        end
        m0_req = 0; m1_req = 0;
        tick(); tick();
    endtask

    task automatic test_fixed_prio();
        do_reset();
        f_m0_req = 1; f_m1_req = 1;
        for (int k = 1; k <= 16; k++) begin
            logic e_g0, e_g1;
            tick();
            e_g0 = (k % 2 == 1) && (((k - 1) / 2) % 4 == 3);
            e_g1 = (k % 2 == 1) && !e_g0;
            n_cmp++;
            if ({f_m0_gnt, f_m1_gnt} !== {e_g0, e_g1}) begin
                n_err++;
                $display("FAIL fx_cycle %0d: gnt0 gnt1 = %b want %b", k, {f_m0_gnt, f_m1_gnt}, {e_g0, e_g1});
            end
        end
        f_m0_req = 0; f_m1_req = 0;
        tick(); tick();
    endtask

    task automatic test_top_addr_collision();
        preload(12'h7FF, 32'hCAFE0000);
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 12'h7FF;
        m1_req = 1; m1_we = 1; m1_addr = 12'h7FF; m1_wdata = 32'h12345678;
        tick();
        n_cmp++;
        if ({m0_gnt, m1_gnt, ram_read_enable} !== 3'b101) begin
            n_err++;
            $display("FAIL col_first: gnt0 gnt1 re = %b want 101", {m0_gnt, m1_gnt, ram_read_enable});
        end
        m0_req = 0;
        tick();
        n_cmp++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hCAFE0000) begin
            n_err++;
            $display("FAIL col_old_read: rvalid=%b rdata=%h want 1 cafe0000", m0_rvalid, m0_rdata);
        end
        tick();
        n_cmp++;
        if ({m0_gnt, m1_gnt, ram_write_enable} !== 3'b011) begin
            n_err++;
            $display("FAIL col_second: gnt0 gnt1 we = %b want 011", {m0_gnt, m1_gnt, ram_write_enable});
        end
        m1_req = 0;
        tick();
        n_cmp++;
        if (mem[12'h7FF] !== 32'h12345678 || m1_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL col_write: mem=%h rvalid1=%b want 12345678 0", mem[12'h7FF], m1_rvalid);
        end
        m0_req = 1; m0_we = 0; m0_addr = 12'h7FF;
        tick();
        m0_req = 0;
        tick();
        n_cmp++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678) begin
            n_err++;
            $display("FAIL col_reread: rvalid=%b rdata=%h want 1 12345678", m0_rvalid, m0_rdata);
        end
        tick();
    endtask

    task automatic test_dropped_req();
        m1_req = 1; m1_we = 1; m1_addr = 12'h030; m1_wdata = 32'h0BADF00D;
        #2;
        m1_req = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({m0_gnt, m1_gnt, ram_write_enable, ram_read_enable} !== 4'b0) begin
                n_err++;
                $display("FAIL drop_cycle %0d: gnt0 gnt1 we re = %b want 0000", k,
                         {m0_gnt, m1_gnt, ram_write_enable, ram_read_enable});
            end
        end
    endtask

    task automatic test_reset_in_access();
        preload(12'h010, 32'h55AA55AA);
        m0_req = 1; m0_we = 1; m0_addr = 12'h010; m0_wdata = 32'h11111111;
        tick();
        n_cmp++;
        if (ram_write_enable !== 1'b1 || m0_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rst_acc_pre: we=%b gnt=%b want 1 1", ram_write_enable, m0_gnt);
        end
        #1;
        rst_n = 1'b0;
        m0_req = 0;
        #1;
        n_cmp++;
        if (ram_write_enable !== 1'b0 || m0_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL rst_acc_async: we=%b gnt=%b want 0 0", ram_write_enable, m0_gnt);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_enable} !== 5'b0) begin
                n_err++;
                $display("FAIL rst_acc_after %0d: gnt0 gnt1 rv0 rv1 we = %b want 00000", k,
                         {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_enable});
            end
        end
        n_cmp++;
        if (mem[12'h010] !== 32'h55AA55AA) begin
            n_err++;
            $display("FAIL rst_acc_mem: mem=%h want 55aa55aa", mem[12'h010]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_prio();
        test_top_addr_collision();
        test_dropped_req();
        test_reset_in_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
